// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle through a single
// shared partial-product generator, valid/ready handshakes on operand and result sides.

module gen_prod #(
   parameter int A_LEN = 256,
   parameter int P_LEN = 320
) (
   input  logic [A_LEN-1:0] i_a,
   input  logic             i_neg,
   input  logic             i_zero,
   input  logic             i_one,
   input  logic             i_two,
   output logic [P_LEN-1:0] o_pp
);
   logic [P_LEN-1:0] w_a_ext;
   logic [P_LEN-1:0] w_mag;

   assign w_a_ext = {{(P_LEN-A_LEN){i_a[A_LEN-1]}}, i_a};

   always_comb begin
      w_mag = '0;
      if (i_zero)
         w_mag = '0;
      else if (i_one)
         w_mag = w_a_ext;
      else if (i_two)
         w_mag = {w_a_ext[P_LEN-2:0], 1'b0};
   end

   assign o_pp = i_neg ? -w_mag : w_mag;
endmodule

module booth_seq_mul #(
   parameter int A_LEN = 256,
   parameter int B_LEN = 64,
   parameter int P_LEN = 320
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_LEN-1:0] a,
   input  logic [B_LEN-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [P_LEN-1:0] prod,
   output logic             busy
);
   localparam int STEPS = B_LEN / 2;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [A_LEN-1:0] r_a_q;
   logic [B_LEN:0]   r_b_q;
   logic [CNT_W-1:0] r_cnt;
   logic [P_LEN-1:0] r_acc;
   logic [P_LEN-1:0] r_prod;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [2:0]       w_trip;
   logic             w_neg;
   logic             w_zero;
   logic             w_one;
   logic             w_two;
   logic [P_LEN-1:0] w_pp;
   logic [P_LEN-1:0] w_pp_shift;
   logic [P_LEN-1:0] w_acc_next;
   logic             w_last;

   // b_q carries an implicit 0 below the LSB, so digit cnt sits at bits 2cnt+2..2cnt
   assign w_trip = r_b_q[{r_cnt, 1'b0} +: 3];

   always_comb begin
      w_neg  = 1'b0;
      w_zero = 1'b0;
      w_one  = 1'b0;
      w_two  = 1'b0;
      case (w_trip)
         3'b000, 3'b111: w_zero = 1'b1;
         3'b001, 3'b010: w_one  = 1'b1;
         3'b011:         w_two  = 1'b1;
         3'b100: begin
            w_two = 1'b1;
            w_neg = 1'b1;
         end
         3'b101, 3'b110: begin
            w_one = 1'b1;
            w_neg = 1'b1;
         end
         default:        w_zero = 1'b1;
      endcase
   end

   gen_prod #(
      .A_LEN (A_LEN),
      .P_LEN (P_LEN)
   ) u_gen_prod (
      .i_a    (r_a_q),
      .i_neg  (w_neg),
      .i_zero (w_zero),
      .i_one  (w_one),
      .i_two  (w_two),
      .o_pp   (w_pp)
   );

   // Bits pushed past the product width are dropped; the final sum is still exact mod 2^P_LEN
   assign w_pp_shift = w_pp << {r_cnt, 1'b0};
   assign w_acc_next = r_acc + w_pp_shift;
   assign w_last     = (r_cnt == CNT_W'(STEPS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a_q       <= '0;
         r_b_q       <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_prod      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a_q      <= a;
                  r_b_q      <= {b, 1'b0};
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_state    <= S_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state     <= S_DONE;
                  r_prod      <= w_acc_next;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign prod      = r_prod;
endmodule
